// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates N functional-unit results onto one registered writeback port.
// Requester 0 has priority; requesters 1..N-1 share round-robin; a starvation counter lets them win periodically.
`default_nettype none

module wb_port_arbiter #(
   parameter int unsigned NR_REQ       = 4,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned TID_W        = 3,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic [NR_REQ-1:0]                req_valid_i,
   output logic [NR_REQ-1:0]                req_ready_o,
   input  logic [NR_REQ-1:0][TID_W-1:0]     req_trans_id_i,
   input  logic [NR_REQ-1:0][DATA_W-1:0]    req_data_i,
   input  logic [NR_REQ-1:0]                req_ex_valid_i,
   output logic                             wb_valid_o,
   input  logic                             wb_ready_i,
   output logic [TID_W-1:0]                 wb_trans_id_o,
   output logic [DATA_W-1:0]                wb_data_o,
   output logic                             wb_ex_valid_o,
   output logic [$clog2(NR_REQ)-1:0]        wb_src_o
);

   localparam int unsigned SRC_W = $clog2(NR_REQ);
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic                 wb_valid_q;
   logic [TID_W-1:0]     wb_tid_q;
   logic [DATA_W-1:0]    wb_data_q;
   logic                 wb_ex_q;
   logic [SRC_W-1:0]     wb_src_q;
   logic [SRC_W-1:0]     rr_ptr_q;
   logic [CNT_W-1:0]     starve_cnt_q;

   logic                 adv;
   logic                 starve;
   logic                 others_valid;
   logic                 rr_found;
   logic [SRC_W-1:0]     rr_idx;
   logic [SRC_W-1:0]     cand;
   logic                 any_sel;
   logic [SRC_W-1:0]     sel_idx;
   logic                 grant;

   // Maps a round-robin offset onto the ring 1..NR_REQ-1, starting at ptr.
   function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] ptr, input int off);
      int v;
      v = ((int'(ptr) - 1 + off) % int'(NR_REQ - 1)) + 1;
      return SRC_W'(v);
   endfunction

   assign adv          = (!wb_valid_q || wb_ready_i) && !flush_i;
   assign starve       = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign others_valid = |req_valid_i[NR_REQ-1:1];

   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int i = 0; i < int'(NR_REQ) - 1; i++) begin
         cand = rr_index(rr_ptr_q, i);
         if (!rr_found && req_valid_i[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   always_comb begin
      any_sel = 1'b1;
      sel_idx = '0;
      if (starve && rr_found) begin
         sel_idx = rr_idx;
      end else if (req_valid_i[0]) begin
         sel_idx = '0;
      end else if (rr_found) begin
         sel_idx = rr_idx;
      end else begin
         any_sel = 1'b0;
      end
   end

   // Gated by rst_ni so no handshake is offered while reset is held.
   assign grant = adv && any_sel && rst_ni;

   for (genvar g = 0; g < int'(NR_REQ); g++) begin : g_ready
      assign req_ready_o[g] = grant && (sel_idx == SRC_W'(g));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_q   <= 1'b0;
         wb_tid_q     <= '0;
         wb_data_q    <= '0;
         wb_ex_q      <= 1'b0;
         wb_src_q     <= '0;
         rr_ptr_q     <= SRC_W'(1);
         starve_cnt_q <= '0;
      end else if (flush_i) begin
         wb_valid_q   <= 1'b0;
         starve_cnt_q <= '0;
      end else if (grant) begin
         wb_valid_q <= 1'b1;
         wb_tid_q   <= req_trans_id_i[sel_idx];
         wb_data_q  <= req_data_i[sel_idx];
         wb_ex_q    <= req_ex_valid_i[sel_idx];
         wb_src_q   <= sel_idx;
         if (sel_idx == '0) begin
            if (others_valid && !starve) begin
               starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
         end else begin
            starve_cnt_q <= '0;
            rr_ptr_q     <= (sel_idx == SRC_W'(NR_REQ - 1)) ? SRC_W'(1) : sel_idx + SRC_W'(1);
         end
      end else if (adv) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign wb_valid_o    = wb_valid_q;
   assign wb_trans_id_o = wb_tid_q;
   assign wb_data_o     = wb_data_q;
   assign wb_ex_valid_o = wb_ex_q;
   assign wb_src_o      = wb_src_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a transaction-level model.
`default_nettype none

module tb_wb_port_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 64;
   localparam int TW    = 3;
   localparam int LIMIT = 3;

   logic                     clk;
   logic                     rst_n;
   logic                     flush;
   logic [NR-1:0]            req_valid;
   logic [NR-1:0]            req_ready;
   logic [NR-1:0][TW-1:0]    req_tid;
   logic [NR-1:0][DW-1:0]    req_data;
   logic [NR-1:0]            req_ex;
   logic                     wb_valid;
   logic                     wb_ready;
   logic [TW-1:0]            wb_tid;
   logic [DW-1:0]            wb_data;
   logic                     wb_ex;
   logic [1:0]               wb_src;

   wb_port_arbiter #(
      .NR_REQ(NR), .DATA_W(DW), .TID_W(TW), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_trans_id_i(req_tid), .req_data_i(req_data), .req_ex_valid_i(req_ex),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
      .wb_trans_id_o(wb_tid), .wb_data_o(wb_data),
      .wb_ex_valid_o(wb_ex), .wb_src_o(wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: the held result plus the arbitration history.
   bit             m_valid;
   logic [TW-1:0]  m_tid;
   logic [DW-1:0]  m_data;
   bit             m_ex;
   int             m_src;
   int             m_rr;
   int             m_cnt;
   int             m_gnt;     // requester granted this cycle, -1 if none
   bit             m_adv;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_valid = 0; m_tid = '0; m_data = '0; m_ex = 0; m_src = 0;
      m_rr = 1; m_cnt = 0;
   endfunction

   // Decide who should be granted given the current inputs and model history.
   function automatic void model_predict();
      int rr_pick;
      int k;
      rr_pick = -1;
      for (int off = 0; off < NR - 1; off++) begin
         k = ((m_rr - 1 + off) % (NR - 1)) + 1;
         if (rr_pick < 0 && req_valid[k]) rr_pick = k;
      end
      m_adv = rst_n && !flush && (!m_valid || wb_ready);
      m_gnt = -1;
      if (m_adv) begin
         if (m_cnt == LIMIT && rr_pick >= 0) m_gnt = rr_pick;
         else if (req_valid[0])              m_gnt = 0;
         else                                m_gnt = rr_pick;
      end
   endfunction

   function automatic void model_update();
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_valid = 0;
         m_cnt   = 0;
      end else if (m_gnt >= 0) begin
         m_valid = 1;
         m_tid   = req_tid[m_gnt];
         m_data  = req_data[m_gnt];
         m_ex    = req_ex[m_gnt];
         m_src   = m_gnt;
         if (m_gnt == 0) begin
            if (req_valid[NR-1:1] != 0 && m_cnt < LIMIT) m_cnt++;
         end else begin
            m_cnt = 0;
            m_rr  = (m_gnt == NR - 1) ? 1 : m_gnt + 1;
         end
      end else if (m_adv) begin
         m_valid = 0;
      end
   endfunction

   function automatic logic [NR-1:0] onehot(input int g);
      logic [NR-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic run_cycle();
      #1;
      model_predict();
      check("req_ready", 64'(req_ready), 64'(onehot(m_gnt)));
      check("wb_valid", 64'(wb_valid), 64'(m_valid));
      if (m_valid) begin
         check("wb_trans_id", 64'(wb_tid), 64'(m_tid));
         check("wb_data", wb_data, m_data);
         check("wb_ex", 64'(wb_ex), 64'(m_ex));
         check("wb_src", 64'(wb_src), 64'(m_src));
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic randomize_payload();
      for (int i = 0; i < NR; i++) begin
         req_tid[i]  = TW'($urandom);
         req_data[i] = {$urandom, $urandom};
         req_ex[i]   = 1'($urandom);
      end
   endtask

   logic [NR-1:0] exp_seq37 [3];
   logic [NR-1:0] exp_seq38 [8];

   initial begin
      exp_seq37 = '{4'b0010, 4'b0100, 4'b0010};
      exp_seq38 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

      rst_n = 1'b0; flush = 1'b0; req_valid = '0; wb_ready = 1'b0;
      req_tid = '0; req_data = '0; req_ex = '0;
      model_reset();
      #2;
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_data", wb_data, 64'd0);
      check("rst_wb_tid", 64'(wb_tid), 64'd0);
      check("rst_wb_src", 64'(wb_src), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin among 1 and 2.
      req_valid = 4'b0110; wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_payload();
         #1 check("rr_seq", 64'(req_ready), 64'(exp_seq37[i]));
         #0;
         run_cycle_rest();
      end

      // Starvation relief for requester 1.
      req_valid = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         randomize_payload();
         #1 check("starve_seq", 64'(req_ready), 64'(exp_seq38[i]));
         run_cycle_rest();
      end

      // Backpressure holds the output stage.
      req_valid = 4'b1111; wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         randomize_payload();
         run_cycle();
      end
      wb_ready = 1'b1;
      #1 check("bp_release", 64'(req_ready), 64'b0001);
      run_cycle_rest();

      // Flush while holding a result, then confirm starvation history was cleared.
      req_valid = 4'b0011;
      run_cycle();
      flush = 1'b1; req_valid = 4'b1111;
      run_cycle();
      flush = 1'b0; req_valid = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         randomize_payload();
         run_cycle();
      end

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         randomize_payload();
         req_valid = NR'($urandom);
         wb_ready  = ($urandom_range(3) != 0);
         flush     = ($urandom_range(19) == 0);
         run_cycle();
      end
      flush = 1'b0;

      // Asynchronous reset while a result is held.
      req_valid = 4'b0001; wb_ready = 1'b1;
      req_data[0] = 64'hDEAD;
      run_cycle();
      wb_ready = 1'b0; req_valid = '0;
      #1 check("pre_rst_valid", 64'(wb_valid), 64'd1);
      check("pre_rst_data", wb_data, 64'hDEAD);
      #1 rst_n = 1'b0;
      #1 check("async_rst_valid", 64'(wb_valid), 64'd0);
      check("async_rst_data", wb_data, 64'd0);
      model_reset();
      @(negedge clk);
      req_valid = 4'b1111; wb_ready = 1'b1;
      run_cycle();
      rst_n = 1'b1; req_valid = 4'b1000;
      #1 check("post_rst_grant", 64'(req_ready), 64'b1000);
      run_cycle_rest();
      check("post_rst_src", 64'(wb_src), 64'd3);
      req_valid = '0;
      run_cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Same as run_cycle but for callers that already spent the 1-unit settle delay.
   task automatic run_cycle_rest();
      model_predict();
      check("req_ready", 64'(req_ready), 64'(onehot(m_gnt)));
      check("wb_valid", 64'(wb_valid), 64'(m_valid));
      if (m_valid) begin
         check("wb_trans_id", 64'(wb_tid), 64'(m_tid));
         check("wb_data", wb_data, m_data);
         check("wb_ex", 64'(wb_ex), 64'(m_ex));
         check("wb_src", 64'(wb_src), 64'(m_src));
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
